// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: instruction-cycle control FSM for the simple CPU.
// Walks IDLE -> S0..S7 (repeating) aligned to the fetch window, driving
// registered PC/IR/ACC/memory/data-bus strobes from opcode and zero.
// HLT parks the machine in HALTED until reset.
// Optional build macro: CTRL_SEQ_SYNC_CHECK_EN enables fetch/sequence
// alignment checking with a sticky sync_err flag.
// Handshake note: there is no valid/ready pairing here; every strobe is a
// single-cycle level that is valid for the whole cycle spent in a state.
module ctrl_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       fetch,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       load_acc,
  output logic       load_ir,
  output logic       rd,
  output logic       wr,
  output logic       datactl_ena,
  output logic       halt,
  output logic       sync_err,
  output logic [3:0] dbg_state
);

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_S0     = 4'd1,
    ST_S1     = 4'd2,
    ST_S2     = 4'd3,
    ST_S3     = 4'd4,
    ST_S4     = 4'd5,
    ST_S5     = 4'd6,
    ST_S6     = 4'd7,
    ST_S7     = 4'd8,
    ST_HALTED = 4'd9
  } state_t;

  // Output vector order: {inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, halt}
  state_t     r_state;
  state_t     w_next_state;
  logic       r_fetch_d;
  logic [7:0] r_out;
  logic [7:0] w_next_out;
  logic       r_sync_err;
  logic       w_sync_fail;
  logic       w_mem_op;

  assign w_mem_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);

  // State register plus registered outputs, fetch history and sticky error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_fetch_d  <= 1'b0;
      r_out      <= 8'h00;
      r_sync_err <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_fetch_d  <= fetch;
      r_out      <= w_next_out;
      r_sync_err <= r_sync_err | w_sync_fail;
    end
  end

  // Next-state logic: start on rising fetch, free-run S0..S7, HLT exits at S3
  always_comb begin
    w_next_state = r_state;
    w_sync_fail  = 1'b0;
    case (r_state)
      ST_IDLE:   if (fetch && !r_fetch_d) w_next_state = ST_S0;
      ST_S0:     w_next_state = ST_S1;
      ST_S1:     w_next_state = ST_S2;
      ST_S2:     w_next_state = ST_S3;
      ST_S3:     w_next_state = (opcode == OP_HLT) ? ST_HALTED : ST_S4;
      ST_S4:     w_next_state = ST_S5;
      ST_S5:     w_next_state = ST_S6;
      ST_S6:     w_next_state = ST_S7;
      ST_S7:     w_next_state = ST_S0;
      ST_HALTED: w_next_state = ST_HALTED;
      default:   w_next_state = ST_IDLE;
    endcase
`ifdef CTRL_SEQ_SYNC_CHECK_EN
    // fetch must be high while in S0-S2 and S7, low while in S3-S6
    case (r_state)
      ST_S0, ST_S1, ST_S2, ST_S7: w_sync_fail = !fetch;
      ST_S3, ST_S4, ST_S5, ST_S6: w_sync_fail = fetch;
      default:                    w_sync_fail = 1'b0;
    endcase
    if (w_sync_fail) w_next_state = ST_IDLE;
`endif
  end

  // Output decode for the state being entered, using opcode/zero at this edge
  always_comb begin
    w_next_out = 8'h00;
    case (w_next_state)
      ST_S0: w_next_out = 8'b0001_1000;
      ST_S1: w_next_out = 8'b1001_1000;
      ST_S3: w_next_out = 8'b1000_0000;
      ST_S4: begin
        if (opcode == OP_JMP)      w_next_out = 8'b0100_0000;
        else if (w_mem_op)         w_next_out = 8'b0000_1000;
        else if (opcode == OP_STO) w_next_out = 8'b0000_0010;
      end
      ST_S5: begin
        if (opcode == OP_JMP)               w_next_out = 8'b0100_0000;
        else if (w_mem_op)                  w_next_out = 8'b0010_1000;
        else if (opcode == OP_STO)          w_next_out = 8'b0000_0110;
        else if (opcode == OP_SKZ && zero)  w_next_out = 8'b1000_0000;
      end
      ST_S6: begin
        if (w_mem_op)              w_next_out = 8'b0000_1000;
        else if (opcode == OP_STO) w_next_out = 8'b0000_0010;
      end
      ST_S7:     if (opcode == OP_SKZ && zero) w_next_out = 8'b1000_0000;
      ST_HALTED: w_next_out = 8'b0000_0001;
      default:   w_next_out = 8'h00;
    endcase
  end

  assign {inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, halt} = r_out;
  assign sync_err  = r_sync_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Testbench for ctrl_sequencer: table-driven instruction vectors plus
// hand-written sequences for HLT, asynchronous reset and fetch alignment.
module tb_ctrl_sequencer;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_HALTED = 4'd9;

  // Expected output byte: {inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, halt}
  typedef struct {
    logic       f;
    logic [2:0] op;
    logic       z;
    logic [7:0] exp;
    logic [3:0] st;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       fetch;
  logic [2:0] opcode;
  logic       zero;
  logic       inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, halt, sync_err;
  logic [3:0] dbg_state;
  logic [7:0] w_out;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  logic exp_sync = 1'b0;

  ctrl_sequencer dut (
    .clk(clk), .reset(reset), .fetch(fetch), .opcode(opcode), .zero(zero),
    .inc_pc(inc_pc), .load_pc(load_pc), .load_acc(load_acc), .load_ir(load_ir),
    .rd(rd), .wr(wr), .datactl_ena(datactl_ena), .halt(halt),
    .sync_err(sync_err), .dbg_state(dbg_state)
  );

  assign w_out = {inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, halt};

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Driver: set inputs at negedge, sample 1 time unit after the next posedge
  task automatic cycle(input logic f, input logic [2:0] op, input logic z);
    @(negedge clk);
    fetch  = f;
    opcode = op;
    zero   = z;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] exp, input logic [3:0] st);
    checks++;
    if (w_out !== exp) begin
      errors++;
      $display("FAIL %s outputs: got %b expected %b", name, w_out, exp);
    end
    checks++;
    if (dbg_state !== st) begin
      errors++;
      $display("FAIL %s state: got %0d expected %0d", name, dbg_state, st);
    end
    checks++;
    if (sync_err !== exp_sync) begin
      errors++;
      $display("FAIL %s sync_err: got %b expected %b", name, sync_err, exp_sync);
    end
    checks++;
    if ((wr && !datactl_ena) || (rd && wr)) begin
      errors++;
      $display("FAIL %s bus rule: rd=%b wr=%b datactl_ena=%b", name, rd, wr, datactl_ena);
    end
  endtask

  // Append one full instruction (S0..S7) with its hand-computed S4..S7 strobes
  task automatic push_instr(input logic [2:0] op, input logic z,
                            input logic [7:0] e4, input logic [7:0] e5,
                            input logic [7:0] e6, input logic [7:0] e7);
    logic [7:0] e[8];
    vec_t v;
    e = '{8'h18, 8'h98, 8'h00, 8'h80, e4, e5, e6, e7};
    for (int k = 0; k < 8; k++) begin
      v.f   = (k < 4);
      v.op  = op;
      v.z   = z;
      v.exp = e[k];
      v.st  = 4'(k + 1);
      vecs.push_back(v);
    end
  endtask

  initial begin
    reset  = 1'b0;
    fetch  = 1'b0;
    opcode = OP_HLT;
    zero   = 1'b0;

    push_instr(OP_LDA, 1'b0, 8'h08, 8'h28, 8'h08, 8'h00);
    push_instr(OP_ADD, 1'b1, 8'h08, 8'h28, 8'h08, 8'h00);
    push_instr(OP_AND, 1'b0, 8'h08, 8'h28, 8'h08, 8'h00);
    push_instr(OP_XOR, 1'b0, 8'h08, 8'h28, 8'h08, 8'h00);
    push_instr(OP_SKZ, 1'b1, 8'h00, 8'h80, 8'h00, 8'h80);
    push_instr(OP_SKZ, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    push_instr(OP_STO, 1'b0, 8'h02, 8'h06, 8'h02, 8'h00);
    push_instr(OP_JMP, 1'b1, 8'h40, 8'h40, 8'h00, 8'h00);

    // Reset state
    #12;
    check("reset", 8'h00, ST_IDLE);
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b0, OP_LDA, 1'b0);
    check("idle_no_fetch", 8'h00, ST_IDLE);

    // Table-driven instruction cycles
    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].f, vecs[i].op, vecs[i].z);
      check($sformatf("vec%0d", i), vecs[i].exp, vecs[i].st);
    end

    // HLT: inc_pc in S3, then halted for 20 fetch periods with noisy inputs
    cycle(1'b1, OP_HLT, 1'b0); check("hlt_s0", 8'h18, 4'd1);
    cycle(1'b1, OP_HLT, 1'b0); check("hlt_s1", 8'h98, 4'd2);
    cycle(1'b1, OP_HLT, 1'b0); check("hlt_s2", 8'h00, 4'd3);
    cycle(1'b1, OP_HLT, 1'b0); check("hlt_s3", 8'h80, 4'd4);
    cycle(1'b0, OP_HLT, 1'b0); check("hlt_enter", 8'h01, ST_HALTED);
    for (int p = 0; p < 20; p++) begin
      for (int k = 0; k < 8; k++) begin
        cycle(k < 4, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        check("halted", 8'h01, ST_HALTED);
      end
    end

    // Reset exits HALTED
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("halt_reset", 8'h00, ST_IDLE);
    @(negedge clk);
    reset = 1'b1;
    fetch = 1'b0;
    @(posedge clk);
    #1;
    check("post_halt_idle", 8'h00, ST_IDLE);

    // LDA up to S5, then asynchronous reset mid-cycle
    cycle(1'b1, OP_LDA, 1'b0); check("lda_s0", 8'h18, 4'd1);
    cycle(1'b1, OP_LDA, 1'b0); check("lda_s1", 8'h98, 4'd2);
    cycle(1'b1, OP_LDA, 1'b0); check("lda_s2", 8'h00, 4'd3);
    cycle(1'b1, OP_LDA, 1'b0); check("lda_s3", 8'h80, 4'd4);
    cycle(1'b0, OP_LDA, 1'b0); check("lda_s4", 8'h08, 4'd5);
    cycle(1'b0, OP_LDA, 1'b0); check("lda_s5", 8'h28, 4'd6);
    #1;
    reset = 1'b0;
    #1;
    check("async_reset", 8'h00, ST_IDLE);
    cycle(1'b1, OP_LDA, 1'b0);
    check("held_in_reset", 8'h00, ST_IDLE);
    @(negedge clk);
    reset = 1'b1;
    fetch = 1'b0;
    @(posedge clk);
    #1;
    check("release_idle", 8'h00, ST_IDLE);
    cycle(1'b1, OP_LDA, 1'b0); check("restart_s0", 8'h18, 4'd1);
    cycle(1'b1, OP_LDA, 1'b0); check("restart_s1", 8'h98, 4'd2);
    cycle(1'b1, OP_LDA, 1'b0); check("restart_s2", 8'h00, 4'd3);
    cycle(1'b1, OP_LDA, 1'b0); check("restart_s3", 8'h80, 4'd4);

    // fetch still high at the S3 edge
    cycle(1'b1, OP_LDA, 1'b0);
`ifdef CTRL_SEQ_SYNC_CHECK_EN
    exp_sync = 1'b1;
    check("sync_fail", 8'h00, ST_IDLE);
    cycle(1'b1, OP_LDA, 1'b0); check("sync_no_rise", 8'h00, ST_IDLE);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, OP_LDA, 1'b0);
      check("sync_wait", 8'h00, ST_IDLE);
    end
    cycle(1'b1, OP_LDA, 1'b0); check("resync_s0", 8'h18, 4'd1);
    cycle(1'b1, OP_LDA, 1'b0); check("resync_s1", 8'h98, 4'd2);
`else
    check("nocheck_s4", 8'h08, 4'd5);
    cycle(1'b0, OP_LDA, 1'b0); check("nocheck_s5", 8'h28, 4'd6);
    cycle(1'b0, OP_LDA, 1'b0); check("nocheck_s6", 8'h08, 4'd7);
    cycle(1'b0, OP_LDA, 1'b0); check("nocheck_s7", 8'h00, 4'd8);
    cycle(1'b1, OP_STO, 1'b0); check("nocheck_s0", 8'h18, 4'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Instruction-cycle control state machine for the simple CPU; sits directly downstream of the clock/phase generator and consumes its `fetch` phase signal.
- Runs an 8-state sequence per instruction, aligned to the fetch window.
- From the current opcode and the accumulator zero flag it drives the strobes for PC, instruction register, accumulator, memory and data-bus control.
- Executes HLT by parking in a halted state until reset.

Parameters:
- OP_HLT, 3'b000, halt opcode
- OP_SKZ, 3'b001, skip next instruction if accumulator zero
- OP_ADD, 3'b010, add memory to accumulator
- OP_AND, 3'b011, AND memory into accumulator
- OP_XOR, 3'b100, XOR memory into accumulator
- OP_LDA, 3'b101, load accumulator from memory
- OP_STO, 3'b110, store accumulator to memory
- OP_JMP, 3'b111, jump to operand address

Ports:
- clk  in  1  system clock; all state changes on posedge
- reset  in  1  asynchronous, active-low reset
- fetch  in  1  fetch phase from clock generator: high 4 cycles, low 4 cycles, repeating
- opcode  in  3  opcode field from the instruction register
- zero  in  1  accumulator-is-zero flag
- inc_pc  out  1  increment program counter
- load_pc  out  1  load PC from IR operand
- load_acc  out  1  load accumulator from ALU result
- load_ir  out  1  load instruction register byte from data bus
- rd  out  1  memory read strobe
- wr  out  1  memory write strobe
- datactl_ena  out  1  drive accumulator onto data bus
- halt  out  1  CPU halted
- sync_err  out  1  fetch/sequence misalignment (see Optional Feature)

Behaviour:
- States: IDLE, S0..S7, HALTED.
- All outputs are registered. The value listed for state Sk holds for the whole cycle spent in Sk. It is computed at the posedge that enters Sk, from `opcode` and `zero` sampled at that edge.
- Reset (reset=0, asynchronous): state=IDLE, internal fetch_d=0, every output 0 including sync_err. Reset asserted at any point mid-instruction aborts immediately; no partial strobes survive.
- IDLE: all outputs 0. Go to S0 at the first posedge where fetch=1 and fetch_d=0 (rising fetch). fetch_d is fetch registered each cycle in every state.
- S0..S6 advance unconditionally to the next state. S7 goes to S0. There is no re-qualification by fetch unless the macro is enabled.
- Per-state outputs (anything not listed is 0):
  - S0: rd, load_ir (IR byte 1)
  - S1: rd, load_ir, inc_pc (IR byte 2)
  - S2: none
  - S3: inc_pc. If opcode=HLT, next state is HALTED instead of S4.
  - S4: JMP gives load_pc. ADD/AND/XOR/LDA give rd. STO gives datactl_ena.
  - S5: JMP gives load_pc. ADD/AND/XOR/LDA give rd and load_acc. STO gives datactl_ena and wr. SKZ with zero=1 gives inc_pc.
  - S6: ADD/AND/XOR/LDA give rd. STO gives datactl_ena.
  - S7: SKZ with zero=1 gives inc_pc.
- wr is never asserted without datactl_ena in the same cycle.
- rd and wr are never asserted together.
- HALTED: halt=1, all other outputs 0. fetch, opcode and zero are ignored. Only reset exits.
- Opcode changes after S1 are not filtered. The IR is expected to hold stable from S2 to S7.
- Net PC movement per instruction:
  - 2 for non-skip instructions.
  - 4 for SKZ taken.
  - Load from operand for JMP.

Optional Feature:
- Macro: CTRL_SEQ_SYNC_CHECK_EN.
- Defined: the sampled fetch is checked at every posedge while in S0..S7.
  - Required value: fetch=1 in S0, S1, S2 and S7; fetch=0 in S3..S6.
  - On mismatch: at that edge, state goes to IDLE, all strobes go to 0, and sync_err is set to 1.
  - sync_err is sticky until reset. The sequencer resynchronises on the next rising fetch; sync_err stays 1.
  - No check is performed in IDLE or HALTED.
- Not defined: no check is performed and sync_err is tied to 0.

Test Plan:
- Reset pulled low during S5 of an LDA → all outputs 0 asynchronously (before the next clk edge). After release, the first rising fetch gives S0 with rd=1, load_ir=1.
- LDA (3'b101), zero=0, normal fetch → rd in S0,S1,S4,S5,S6; load_acc only in S5; inc_pc in S1,S3; wr and datactl_ena never asserted.
- SKZ (3'b001): with zero=1, inc_pc pulses in S1,S3,S5,S7 (4 total); with zero=0, only S1,S3 (2 total).
- STO (3'b110) → datactl_ena in S4,S5,S6; wr only in S5; rd only in S0,S1.
- HLT (3'b000) → inc_pc in S3, then halt=1 from the next cycle. halt stays 1 with no other strobe for 20+ fetch periods, until reset=0.
- CTRL_SEQ_SYNC_CHECK_EN defined, fetch held 1 through S3 → next cycle: state IDLE, all strobes 0, sync_err=1. sync_err remains 1 after the next normal fetch rise restarts S0.
